// File: rtl/m_serial_adder_if.sv
// m_serial_adder_if: start/operand/result bundle for the bit-serial adder (w_ovf only with SERIAL_ADDER_OVF_EN)
interface m_serial_adder_if #(parameter int N = 8);
  logic         w_start;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic         w_busy;
  logic         w_done;
  logic [N-1:0] w_sum;
  logic         w_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         w_ovf;
`endif
  modport master (
    output w_start, w_a, w_b,
    input  w_busy, w_done, w_sum, w_cout
`ifdef SERIAL_ADDER_OVF_EN
    , input w_ovf
`endif
  );
  modport slave (
    input  w_start, w_a, w_b,
    output w_busy, w_done, w_sum, w_cout
`ifdef SERIAL_ADDER_OVF_EN
    , output w_ovf
`endif
  );
endinterface

// File: rtl/m_serial_adder.sv
// m_serial_adder: bit-serial N-bit adder from two half-adders plus carry flop; SERIAL_ADDER_OVF_EN adds signed overflow
module m_half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_c,
  output logic o_s
);
  assign o_c = i_a & i_b;
  assign o_s = i_a ^ i_b;
endmodule

module m_serial_adder #(parameter int N = 8) (
  input logic              w_clk,
  input logic              w_rst,
  m_serial_adder_if.slave  bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        r_state, w_next;
  logic [N-1:0]  r_a, r_b, r_s;
  logic          r_c, r_cout;
  logic [CW-1:0] r_cnt;
  logic          w_c0, w_s0, w_c1, w_bit, w_nc, w_last, w_accept;
`ifdef SERIAL_ADDER_OVF_EN
  logic          r_ovf;
`endif
  m_half_adder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_c(w_c0), .o_s(w_s0));
  m_half_adder u_ha1 (.i_a(w_s0),   .i_b(r_c),    .o_c(w_c1), .o_s(w_bit));
  assign w_nc     = w_c0 | w_c1;
  assign w_last   = r_cnt == CW'(N - 1);
  assign w_accept = (r_state == IDLE) && bus.w_start;
  // state register
  always_ff @(posedge w_clk)
    r_state <= w_rst ? IDLE : w_next;
  // next state: start only honoured in IDLE, DONE always returns to IDLE
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (bus.w_start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  // datapath: latch on accept, then shift one bit per RUN edge LSB first
  always_ff @(posedge w_clk) begin
    if (w_rst || w_accept) begin
      r_a    <= w_rst ? '0 : bus.w_a;
      r_b    <= w_rst ? '0 : bus.w_b;
      r_s    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_s   <= N'({w_bit, r_s} >> 1);
      r_c   <= w_nc;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_nc;
`ifdef SERIAL_ADDER_OVF_EN
        r_ovf  <= r_c ^ w_nc;
`endif
      end
    end
  end
  assign bus.w_busy = r_state == RUN;
  assign bus.w_done = r_state == DONE;
  assign bus.w_sum  = r_s;
  assign bus.w_cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.w_ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_m_serial_adder.sv
// tb_m_serial_adder: directed checks of the serial adder at N=8 and N=1
module tb_m_serial_adder;
  logic w_clk = 1'b0;
  logic w_rst;
  always #5 w_clk = ~w_clk;
  m_serial_adder_if #(.N(8)) bus ();
  m_serial_adder_if #(.N(1)) bus1 ();
  m_serial_adder #(.N(8)) dut  (.w_clk(w_clk), .w_rst(w_rst), .bus(bus));
  m_serial_adder #(.N(1)) dut1 (.w_clk(w_clk), .w_rst(w_rst), .bus(bus1));
  int tests = 0;
  int fails = 0;
  int ndone;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec, input logic eo);
    int lat = 0;
    int busy = 0;
    bus.w_a = a;
    bus.w_b = b;
    bus.w_start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge w_clk);
      if (k == 1) begin
        bus.w_start = 1'b0;
        bus.w_a = ~a;
        bus.w_b = ~b;
      end
      busy += int'(bus.w_busy);
      if (bus.w_done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busy"}, busy, 8);
    chk({tag, "_sum"}, bus.w_sum, es);
    chk({tag, "_cout"}, bus.w_cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, bus.w_ovf, eo);
`else
    chk({tag, "_eo"}, eo, eo ^ 1'b0);
`endif
    @(negedge w_clk);
    chk({tag, "_pulse"}, {bus.w_done, bus.w_busy}, 2'b00);
    chk({tag, "_hold"}, bus.w_sum, es);
  endtask
  task automatic run1(input string tag, input logic a, input logic b,
                      input logic es, input logic ec, input logic eo);
    int lat = 0;
    int busy = 0;
    bus1.w_a = a;
    bus1.w_b = b;
    bus1.w_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge w_clk);
      if (k == 1) bus1.w_start = 1'b0;
      busy += int'(bus1.w_busy);
      if (bus1.w_done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_sum"}, bus1.w_sum, es);
    chk({tag, "_cout"}, bus1.w_cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, bus1.w_ovf, eo);
`endif
    @(negedge w_clk);
  endtask
  initial begin
    w_rst = 1'b1;
    bus.w_start = 1'b0;
    bus.w_a = '0;
    bus.w_b = '0;
    bus1.w_start = 1'b0;
    bus1.w_a = '0;
    bus1.w_b = '0;
    @(negedge w_clk);
    @(negedge w_clk);
    chk("rst_busy", bus.w_busy, 1'b0);
    chk("rst_done", bus.w_done, 1'b0);
    chk("rst_sum", bus.w_sum, 8'h00);
    chk("rst_cout", bus.w_cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", bus.w_ovf, 1'b0);
`endif
    w_rst = 1'b0;
    @(negedge w_clk);
    run_op("a5a_b33", 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1);
    run_op("aff_b01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("a00_b00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("a7f_b01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op("a80_b80", 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    bus.w_a = 8'h10;
    bus.w_b = 8'h20;
    bus.w_start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 29; k++) begin
      @(negedge w_clk);
      bus.w_a = (k <= 5) ? 8'hAA : 8'h10;
      if (bus.w_done) begin
        ndone++;
        chk("hold_pos", k, 9 + 10 * (ndone - 1));
        chk("hold_sum", bus.w_sum, 8'h30);
      end
    end
    bus.w_start = 1'b0;
    chk("hold_cnt", ndone, 3);
    @(negedge w_clk);
    chk("hold_idle", {bus.w_done, bus.w_busy}, 2'b00);
    bus.w_a = 8'h07;
    bus.w_b = 8'h00;
    bus.w_start = 1'b1;
    @(negedge w_clk);
    bus.w_start = 1'b0;
    repeat (3) @(negedge w_clk);
    chk("mid_busy_pre", bus.w_busy, 1'b1);
    w_rst = 1'b1;
    @(negedge w_clk);
    chk("mid_busy", bus.w_busy, 1'b0);
    chk("mid_done", bus.w_done, 1'b0);
    chk("mid_sum", bus.w_sum, 8'h00);
    chk("mid_cout", bus.w_cout, 1'b0);
    w_rst = 1'b0;
    repeat (12) @(negedge w_clk);
    chk("mid_stay_idle", {bus.w_done, bus.w_busy}, 2'b00);
    w_rst = 1'b1;
    bus.w_start = 1'b1;
    @(negedge w_clk);
    chk("rst_wins", bus.w_busy, 1'b0);
    w_rst = 1'b0;
    bus.w_start = 1'b0;
    @(negedge w_clk);
    run_op("a01_b02", 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    run1("n1_11", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    run1("n1_10", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
